// File: rtl/board_pkg.sv
// Shared definitions for the board sequencer.
// STATE_BITS : width of the reported state code
// state_e    : sequencer states (IDLE..FAULT); unused codes fall back to IDLE
package board_pkg;
  localparam int STATE_BITS = 3;

  typedef enum logic [STATE_BITS-1:0] {
    IDLE     = 3'd0,
    STARTUP  = 3'd1,
    RUNNING  = 3'd2,
    SHUTDOWN = 3'd3,
    FAULT    = 3'd4
  } state_e;
endpackage

// File: rtl/board_sequencer_if.sv
// Enable/ready handshake bundle between the sequencer and its subsystems.
// sub_en    : sequencer -> subsystem i enable
// sub_ready : subsystem i -> sequencer, 1 = up, 0 = down
// master = sequencer side, slave = subsystem side
interface board_sequencer_if #(
  parameter int NUM_SUBSYS = 4
);
  logic [NUM_SUBSYS-1:0] sub_en;
  logic [NUM_SUBSYS-1:0] sub_ready;

  modport master (output sub_en, input  sub_ready);
  modport slave  (input  sub_en, output sub_ready);
endinterface

// File: rtl/button_debounce.sv
// Synchronises and debounces the raw command button.
// clk, rst : clock, synchronous active-high reset
// btn      : raw asynchronous button
// level    : debounced button level
// press    : one-cycle pulse on the debounced 0->1 transition
// Stable raw high first sampled at edge k gives press high after edge k+2+DEBOUNCE_CYCLES.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        level <= sync2;
        press <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/board_sequencer.sv
// Board power/mode sequencer: enables subsystems in order with per-stage ready
// handshakes and timeouts, disables them in reverse, latches faults.
// clk, rst : clock, synchronous active-high reset
// btn      : raw user command button
// bus      : sub_en out / sub_ready in handshake (master side)
// state    : current state code (board_pkg::state_e)
// fault    : latched fault flag, cleared by a press in FAULT
// led      : status display (off / stage thermometer / all on / blinking)
module board_sequencer
  import board_pkg::*;
#(
  parameter int NUM_SUBSYS      = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STAGE_TIMEOUT   = 5000000,
  parameter int BLINK_DIV       = 2500000,
  parameter int LED_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn,
  board_sequencer_if.master     bus,
  output logic [STATE_BITS-1:0] state,
  output logic                  fault,
  output logic [LED_WIDTH-1:0]  led
);
  localparam int IW = (NUM_SUBSYS    > 1) ? $clog2(NUM_SUBSYS)    : 1;
  localparam int TW = (STAGE_TIMEOUT > 1) ? $clog2(STAGE_TIMEOUT) : 1;
  localparam int BW = (BLINK_DIV     > 1) ? $clog2(BLINK_DIV)     : 1;
  localparam logic [NUM_SUBSYS-1:0] ONE = NUM_SUBSYS'(1);

  state_e                st;
  logic [IW-1:0]         idx;
  logic [TW-1:0]         timer;
  logic [BW-1:0]         blink;
  logic [NUM_SUBSYS-1:0] en_q;
  logic                  btn_level, btn_rise, press;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .level (btn_level),
    .press (btn_rise)
  );

  // A rise pulse is only meaningful while the debounced level is high.
  assign press = btn_rise & btn_level;

  assign bus.sub_en = en_q;
  assign state      = st;

  // Enable patterns for the next stage up, dropping the current stage,
  // and dropping the stage below the current one.
  logic [NUM_SUBSYS-1:0] en_add, en_drop, en_dec, en_top_off;
  assign en_add     = en_q |  ((ONE << idx) << 1);
  assign en_drop    = en_q & ~(ONE << idx);
  assign en_dec     = en_q & ~((ONE << idx) >> 1);
  assign en_top_off = en_q & ~(ONE << (NUM_SUBSYS - 1));

  // Thermometer of the number of enabled stages, truncated to the LED width.
  function automatic logic [LED_WIDTH-1:0] therm(input logic [NUM_SUBSYS-1:0] en);
    int p;
    p = 0;
    for (int i = 0; i < NUM_SUBSYS; i++) p += int'(en[i]);
    therm = '0;
    for (int i = 0; i < LED_WIDTH; i++) therm[i] = (i < p);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      idx   <= '0;
      timer <= '0;
      blink <= '0;
      en_q  <= '0;
      fault <= 1'b0;
      led   <= '0;
    end else begin
      case (st)
        IDLE: begin
          en_q  <= '0;
          led   <= '0;
          timer <= '0;
          if (press) begin
            st   <= STARTUP;
            idx  <= '0;
            en_q <= ONE;
            led  <= therm(ONE);
          end
        end
        STARTUP: begin
          // press > ready > timeout
          if (press) begin
            st    <= SHUTDOWN;
            timer <= '0;
            en_q  <= en_drop;
            led   <= therm(en_drop);
          end else if (bus.sub_ready[idx]) begin
            timer <= '0;
            if (idx == IW'(NUM_SUBSYS - 1)) begin
              st  <= RUNNING;
              led <= '1;
            end else begin
              idx  <= idx + 1'b1;
              en_q <= en_add;
              led  <= therm(en_add);
            end
          end else if (timer == TW'(STAGE_TIMEOUT - 1)) begin
            st    <= FAULT;
            fault <= 1'b1;
            en_q  <= '0;
            led   <= '1;
            blink <= '0;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RUNNING: begin
          timer <= '0;
          // losing a subsystem wins over a shutdown request
          if (!(&bus.sub_ready)) begin
            st    <= FAULT;
            fault <= 1'b1;
            en_q  <= '0;
            led   <= '1;
            blink <= '0;
          end else if (press) begin
            st   <= SHUTDOWN;
            idx  <= IW'(NUM_SUBSYS - 1);
            en_q <= en_top_off;
            led  <= therm(en_top_off);
          end
        end
        SHUTDOWN: begin
          // sub_en[idx] is already low here; wait for that stage to report down
          if (!bus.sub_ready[idx]) begin
            timer <= '0;
            if (idx == '0) begin
              st   <= IDLE;
              en_q <= '0;
              led  <= '0;
            end else begin
              idx  <= idx - 1'b1;
              en_q <= en_dec;
              led  <= therm(en_dec);
            end
          end else if (timer == TW'(STAGE_TIMEOUT - 1)) begin
            st    <= FAULT;
            fault <= 1'b1;
            en_q  <= '0;
            led   <= '1;
            blink <= '0;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FAULT: begin
          en_q  <= '0;
          timer <= '0;
          if (press) begin
            st    <= IDLE;
            fault <= 1'b0;
            led   <= '0;
            blink <= '0;
          end else if (blink == BW'(BLINK_DIV - 1)) begin
            led   <= ~led;
            blink <= '0;
          end else begin
            blink <= blink + 1'b1;
          end
        end
        default: begin
          st    <= IDLE;
          idx   <= '0;
          timer <= '0;
          en_q  <= '0;
          led   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_board_sequencer.sv
module tb_board_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [2:0] state;
  logic       fault;
  logic [7:0] led;

  int checks = 0;
  int errors = 0;

  board_sequencer_if #(.NUM_SUBSYS(4)) bus ();

  board_sequencer #(
    .NUM_SUBSYS(4), .DEBOUNCE_CYCLES(4), .STAGE_TIMEOUT(16),
    .BLINK_DIV(8), .LED_WIDTH(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .bus   (bus),
    .state (state),
    .fault (fault),
    .led   (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       do_press;
    logic [3:0] rdy;
    int         wait_n;
    logic [2:0] st;
    logic [3:0] en;
    logic [7:0] led;
  } vec_t;

  vec_t tbl [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [2:0] s, input logic [3:0] e,
                         input logic [7:0] l, input logic f);
    chk({name, ".state"}, 32'(state), 32'(s));
    chk({name, ".sub_en"}, 32'(bus.sub_en), 32'(e));
    chk({name, ".led"}, 32'(led), 32'(l));
    chk({name, ".fault"}, 32'(fault), 32'(f));
  endtask

  // Hold the button until the debounced press is pending for the next edge.
  task automatic press_btn();
    btn = 1'b1;
    repeat (7) tick();
    btn = 1'b0;
  endtask

  task automatic release_wait();
    btn = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // full on/off sequence, ready 3 cycles after each enable
    tbl[0]  = '{1'b1, 4'b0000, 1, 3'd1, 4'b0001, 8'h01};
    tbl[1]  = '{1'b0, 4'b0000, 3, 3'd1, 4'b0001, 8'h01};
    tbl[2]  = '{1'b0, 4'b0001, 1, 3'd1, 4'b0011, 8'h03};
    tbl[3]  = '{1'b0, 4'b0001, 3, 3'd1, 4'b0011, 8'h03};
    tbl[4]  = '{1'b0, 4'b0011, 1, 3'd1, 4'b0111, 8'h07};
    tbl[5]  = '{1'b0, 4'b0011, 3, 3'd1, 4'b0111, 8'h07};
    tbl[6]  = '{1'b0, 4'b0111, 1, 3'd1, 4'b1111, 8'h0F};
    tbl[7]  = '{1'b0, 4'b0111, 3, 3'd1, 4'b1111, 8'h0F};
    tbl[8]  = '{1'b0, 4'b1111, 1, 3'd2, 4'b1111, 8'hFF};
    tbl[9]  = '{1'b0, 4'b1111, 3, 3'd2, 4'b1111, 8'hFF};
    tbl[10] = '{1'b1, 4'b1111, 1, 3'd3, 4'b0111, 8'h07};
    tbl[11] = '{1'b0, 4'b1111, 2, 3'd3, 4'b0111, 8'h07};
    tbl[12] = '{1'b0, 4'b0111, 1, 3'd3, 4'b0011, 8'h03};
    tbl[13] = '{1'b0, 4'b0011, 1, 3'd3, 4'b0001, 8'h01};
    tbl[14] = '{1'b0, 4'b0001, 1, 3'd3, 4'b0000, 8'h00};
    tbl[15] = '{1'b0, 4'b0000, 1, 3'd0, 4'b0000, 8'h00};

    rst = 1'b1;
    btn = 1'b0;
    bus.sub_ready = 4'b0000;
    repeat (2) tick();
    chk_all("reset", 3'd0, 4'b0000, 8'h00, 1'b0);
    rst = 1'b0;

    // bouncing button never produces a press
    for (int i = 0; i < 20; i++) begin
      btn = ((i / 2) % 2 == 0);
      tick();
      chk("bounce.state", 32'(state), 32'd0);
    end
    // held high: press registered after edge k+6, FSM acts at k+7
    btn = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (j <= 7) chk("press_lat.idle", 32'(state), 32'd0);
      else        chk_all("press_lat.start", 3'd1, 4'b0001, 8'h01, 1'b0);
      if (j == 7) chk("press_pulse", 32'(dut.u_deb.press), 32'd1);
    end
    btn = 1'b0;

    // startup timeout: FAULT 16 cycles after stage 0 enable
    for (int m = 1; m <= 16; m++) begin
      tick();
      if (m == 15) chk("tmo.wait", 32'(state), 32'd1);
      if (m == 16) chk_all("tmo.fault", 3'd4, 4'b0000, 8'hFF, 1'b1);
    end
    for (int b = 1; b <= 16; b++) begin
      tick();
      chk("blink.led", 32'(led), (b < 8 || b == 16) ? 32'hFF : 32'h00);
    end
    release_wait();
    press_btn();
    tick();
    chk_all("fault_clear", 3'd0, 4'b0000, 8'h00, 1'b0);

    release_wait();
    for (int v = 0; v < 16; v++) begin
      if (tbl[v].do_press) press_btn();
      bus.sub_ready = tbl[v].rdy;
      repeat (tbl[v].wait_n) tick();
      chk_all($sformatf("seq%0d", v), tbl[v].st, tbl[v].en, tbl[v].led, 1'b0);
    end

    // running fault: ready drop together with press
    release_wait();
    bus.sub_ready = 4'b1111;
    press_btn();
    repeat (5) tick();
    chk_all("run.up", 3'd2, 4'b1111, 8'hFF, 1'b0);
    release_wait();
    press_btn();
    bus.sub_ready = 4'b1011;
    tick();
    chk_all("run.fault", 3'd4, 4'b0000, 8'hFF, 1'b1);
    release_wait();
    bus.sub_ready = 4'b0000;
    press_btn();
    tick();
    chk_all("run.clear", 3'd0, 4'b0000, 8'h00, 1'b0);

    // abort at idx=1; press lands on the final timeout cycle and must win
    release_wait();
    press_btn();
    tick();
    bus.sub_ready = 4'b0001;
    tick();
    chk_all("abort.idx1", 3'd1, 4'b0011, 8'h03, 1'b0);
    release_wait();
    press_btn();
    tick();
    chk_all("abort.sd1", 3'd3, 4'b0001, 8'h01, 1'b0);
    tick();
    chk_all("abort.sd0", 3'd3, 4'b0000, 8'h00, 1'b0);
    bus.sub_ready = 4'b0000;
    tick();
    chk_all("abort.idle", 3'd0, 4'b0000, 8'h00, 1'b0);

    // reset in the middle of startup
    release_wait();
    bus.sub_ready = 4'b0011;
    press_btn();
    repeat (3) tick();
    chk_all("rst.pre", 3'd1, 4'b0111, 8'h07, 1'b0);
    rst = 1'b1;
    tick();
    chk_all("rst.mid", 3'd0, 4'b0000, 8'h00, 1'b0);
    rst = 1'b0;
    bus.sub_ready = 4'b0000;
    tick();
    chk_all("rst.after", 3'd0, 4'b0000, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
